// File: rtl/key_gene.sv
// RC4 core: 256-byte S-box with key scheduling (KSA) and keystream
// generation (PRGA); the phase is chosen each cycle by NS.
// Optional build macro: KEY_GENE_SBOX_PEEK_EN -- in INIT and KEY_GENE,
// test shows S[count[7:0]] after that cycle's update.
module key_gene (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_init,
    input  logic [1:0] NS,
    output logic       data_rready,
    output logic [8:0] count,
    output logic [7:0] j,
    output logic       flag_ex,
    output logic [7:0] test
);

    localparam logic [1:0] INIT       = 2'b00;
    localparam logic [1:0] KEY_GENE   = 2'b01;
    localparam logic [1:0] EN_DE_CODE = 2'b10;

    logic [7:0] sbox [256];

    logic       ksa_step;
    logic       prga_prep;
    logic       prga_step;
    logic [7:0] idx_i;
    logic [7:0] idx_jn;
    logic [7:0] s_i;
    logic [7:0] s_jn;
    logic [7:0] out_idx;
    logic [7:0] out_byte;

    // Decode the phase and form the swap indices; KSA and PRGA share one swap port
    always_comb begin
        ksa_step  = (NS == KEY_GENE) && !count[8];
        prga_prep = (NS == EN_DE_CODE) && data_rready && count[8];
        prga_step = (NS == EN_DE_CODE) && data_rready && !count[8];
        idx_i     = prga_step ? (count[7:0] + 8'd1) : count[7:0];
        s_i       = sbox[idx_i];
        idx_jn    = prga_step ? (j + s_i) : (j + s_i + key_init);
        s_jn      = sbox[idx_jn];
        // Pre-swap sum equals the textbook post-swap sum since the two entries just trade places
        out_idx   = s_i + s_jn;
        out_byte  = sbox[out_idx];
    end

`ifdef KEY_GENE_SBOX_PEEK_EN
    logic [7:0] peek_idx;
    logic [7:0] peek_val;

    // Value of S[count[7:0]] as it will look after this cycle's update
    always_comb begin
        peek_idx = ksa_step ? (count[7:0] + 8'd1) : count[7:0];
        peek_val = sbox[peek_idx];
        if (ksa_step) begin
            if (peek_idx == idx_i) begin
                peek_val = s_jn;
            end else if (peek_idx == idx_jn) begin
                peek_val = s_i;
            end
        end
    end
`endif

    // S-box storage: identity on reset/INIT, one swap per KSA or PRGA step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 256; k++) begin
                sbox[k] <= 8'(k);
            end
        end else if (NS == INIT) begin
            for (int k = 0; k < 256; k++) begin
                sbox[k] <= 8'(k);
            end
        end else if (ksa_step || prga_step) begin
            // When idx_i == idx_jn both writes carry the same value
            sbox[idx_i]  <= s_jn;
            sbox[idx_jn] <= s_i;
        end
    end

    // Index, status and keystream registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= 9'd0;
            j           <= 8'd0;
            data_rready <= 1'b0;
            flag_ex     <= 1'b0;
            test        <= 8'd0;
        end else begin
            flag_ex <= 1'b0;
            case (NS)
                INIT: begin
                    count       <= 9'd0;
                    j           <= 8'd0;
                    data_rready <= 1'b0;
`ifdef KEY_GENE_SBOX_PEEK_EN
                    test        <= 8'd0;
`endif
                end
                KEY_GENE: begin
                    if (ksa_step) begin
                        count   <= count + 9'd1;
                        j       <= idx_jn;
                        flag_ex <= 1'b1;
                        if (count == 9'd255) begin
                            data_rready <= 1'b1;
                        end
                    end
`ifdef KEY_GENE_SBOX_PEEK_EN
                    test <= peek_val;
`endif
                end
                EN_DE_CODE: begin
                    if (prga_prep) begin
                        count <= 9'd0;
                        j     <= 8'd0;
                    end else if (prga_step) begin
                        count   <= {1'b0, idx_i};
                        j       <= idx_jn;
                        flag_ex <= 1'b1;
                        test    <= out_byte;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_gene.sv
// Directed bench for key_gene (default build) using the RC4 key "Key".
module tb_key_gene;

    localparam logic [1:0] INIT       = 2'b00;
    localparam logic [1:0] KEY_GENE   = 2'b01;
    localparam logic [1:0] EN_DE_CODE = 2'b10;
    localparam logic [1:0] HOLD       = 2'b11;

    logic       clk;
    logic       rst;
    logic [7:0] key_init;
    logic [1:0] NS;
    logic       data_rready;
    logic [8:0] count;
    logic [7:0] j;
    logic       flag_ex;
    logic [7:0] test;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] key_bytes [3] = '{8'h4B, 8'h65, 8'h79};
    logic [7:0] exp_ks    [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72,
                                  8'hA7};

    key_gene dut (
        .clk        (clk),
        .rst        (rst),
        .key_init   (key_init),
        .NS         (NS),
        .data_rready(data_rready),
        .count      (count),
        .j          (j),
        .flag_ex    (flag_ex),
        .test       (test)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, clock once, sample 1 time unit after the edge
    task automatic step(input logic [1:0] ns, input logic [7:0] key);
        NS       = ns;
        key_init = key;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        NS = INIT;
        key_init = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) step(INIT, 8'h00);
        vectors++;
        if (count !== 9'd0 || j !== 8'd0 || data_rready !== 1'b0 || flag_ex !== 1'b0
            || test !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_init: count=%0d j=%h rdy=%b flag=%b test=%h, want 0/00/0/0/00",
                     count, j, data_rready, flag_ex, test);
        end
    endtask

    task automatic test_ksa_first_steps();
        step(INIT, 8'h00);
        step(KEY_GENE, 8'h00);
        vectors++;
        if (j !== 8'h00 || count !== 9'd1 || flag_ex !== 1'b1) begin
            miscompares++;
            $display("FAIL ksa_step1: j=%h count=%0d flag=%b, want 00/1/1", j, count, flag_ex);
        end
        step(KEY_GENE, 8'h01);
        vectors++;
        if (j !== 8'h02 || count !== 9'd2 || flag_ex !== 1'b1) begin
            miscompares++;
            $display("FAIL ksa_step2: j=%h count=%0d flag=%b, want 02/2/1", j, count, flag_ex);
        end
    endtask

    task automatic test_enc_not_ready();
        // Continues from count=2, j=2 left by the previous task
        for (int c = 0; c < 3; c++) begin
            step(EN_DE_CODE, 8'h00);
            vectors++;
            if (count !== 9'd2 || j !== 8'h02 || flag_ex !== 1'b0 || data_rready !== 1'b0
                || test !== 8'h00) begin
                miscompares++;
                $display("FAIL enc_not_ready[%0d]: count=%0d j=%h flag=%b rdy=%b test=%h, want 2/02/0/0/00",
                         c, count, j, flag_ex, data_rready, test);
            end
        end
        step(HOLD, 8'h00);
        vectors++;
        if (count !== 9'd2 || j !== 8'h02 || flag_ex !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_code: count=%0d j=%h flag=%b, want 2/02/0", count, j, flag_ex);
        end
    endtask

    task automatic run_ksa(input string tag);
        step(INIT, 8'h00);
        for (int n = 1; n <= 256; n++) begin
            step(KEY_GENE, key_bytes[(n - 1) % 3]);
            vectors++;
            if (count !== 9'(n) || flag_ex !== 1'b1 || data_rready !== (n == 256)) begin
                miscompares++;
                $display("FAIL %s_ksa[%0d]: count=%0d flag=%b rdy=%b, want %0d/1/%0d",
                         tag, n, count, flag_ex, data_rready, n, (n == 256));
            end
        end
        for (int c = 0; c < 2; c++) begin
            step(KEY_GENE, 8'h55);
            vectors++;
            if (count !== 9'd256 || flag_ex !== 1'b0 || data_rready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_ksa_extra[%0d]: count=%0d flag=%b rdy=%b, want 256/0/1",
                         tag, c, count, flag_ex, data_rready);
            end
        end
    endtask

    task automatic run_prga(input string tag);
        step(EN_DE_CODE, 8'h00);
        vectors++;
        if (count !== 9'd0 || j !== 8'h00 || flag_ex !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_prep: count=%0d j=%h flag=%b, want 0/00/0", tag, count, j, flag_ex);
        end
        for (int n = 0; n < 9; n++) begin
            step(EN_DE_CODE, 8'h00);
            vectors++;
            if (test !== exp_ks[n] || flag_ex !== 1'b1 || count !== 9'(n + 1)) begin
                miscompares++;
                $display("FAIL %s_ks[%0d]: test=%h flag=%b count=%0d, want %h/1/%0d",
                         tag, n, test, flag_ex, count, exp_ks[n], n + 1);
            end
        end
    endtask

    task automatic test_keystream();
        run_ksa("first");
        run_prga("first");
    endtask

    task automatic test_reset_mid_prga();
        step(EN_DE_CODE, 8'h00);
        // Assert asynchronously between edges and check before any clock edge
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (count !== 9'd0 || j !== 8'h00 || data_rready !== 1'b0 || test !== 8'h00
            || flag_ex !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d j=%h rdy=%b test=%h flag=%b, want 0/00/0/00/0",
                     count, j, data_rready, test, flag_ex);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Without INIT, identity S-box must give j=0 then j=2
        step(KEY_GENE, 8'h00);
        step(KEY_GENE, 8'h01);
        vectors++;
        if (j !== 8'h02 || count !== 9'd2) begin
            miscompares++;
            $display("FAIL reset_identity: j=%h count=%0d, want 02/2", j, count);
        end
        run_ksa("again");
        run_prga("again");
    endtask

    initial begin
        rst      = 1'b0;
        NS       = INIT;
        key_init = 8'h00;
        test_reset();
        test_ksa_first_steps();
        test_enc_not_ready();
        test_keystream();
        test_reset_mid_prga();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
